// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART_TX byte port between N_REQ byte-stream requesters.
//   Round-robin packet-level arbitration: a grant is held until the owner's
//   last byte is accepted, then an idle gap of GAP_CYCLES clocks follows.
//
// Optional feature (macro UART_TX_ARB_TIMEOUT_EN):
//   A granted owner that stalls (req_valid low) for TIMEOUT_CYCLES XFER
//   cycles loses its grant; timeout_err pulses for one cycle and the
//   arbiter returns straight to IDLE. Without the macro no counter is built
//   and timeout_err is tied low.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_data[8*N_REQ]   per-requester byte, requester i on [8i+7:8i]
//   req_valid/req_last  per-requester valid and end-of-packet flags
//   req_ready           per-requester accept (only the owner can see 1)
//   tx_data/tx_valid    byte stream to UART_TX
//   tx_ready            UART_TX ready
//   grant               one-hot owner, zero outside XFER
//   busy                high in XFER or GAP
//   timeout_err         one-cycle pulse on a timeout revoke
module uart_tx_arbiter #(
   parameter int N_REQ          = 2,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
   localparam logic [IW-1:0] RR_INIT  = IW'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("uart_tx_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      rr_q, rr_d;
   logic [GW-1:0]      gap_q, gap_d;

   logic               sel_found;
   logic [IW-1:0]      sel_idx;
   logic               in_xfer, g_valid, g_last, hs;
   logic [7:0]         g_data;

   // Round-robin search starting just after the last owner.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!sel_found && req_valid[idx]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(idx);
         end
      end
   end

   // Pass-through datapath from the current owner.
   assign in_xfer   = (state_q == S_XFER);
   assign g_valid   = req_valid[gidx_q];
   assign g_last    = req_last[gidx_q];
   assign g_data    = req_data[gidx_q*8 +: 8];
   assign tx_valid  = in_xfer & g_valid;
   assign tx_data   = tx_valid ? g_data : 8'h00;
   assign hs        = tx_valid & tx_ready;
   assign req_ready = hs ? grant_q : '0;
   assign grant     = grant_q;
   assign busy      = (state_q != S_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] to_q, to_d;
   logic          to_err_q, to_err_d;
   assign timeout_err = to_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
      gap_d   = gap_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_d     = to_q;
      to_err_d = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
               gidx_d  = sel_idx;
               rr_d    = sel_idx;
               state_d = S_XFER;
`ifdef UART_TX_ARB_TIMEOUT_EN
               to_d    = '0;
`endif
            end
         end
         S_XFER: begin
            if (hs && g_last) begin
               grant_d = '0;
               if (GAP_CYCLES > 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (hs) begin
               to_d = '0;
            end else if (!g_valid) begin
               if (to_q == TO_LAST) begin
                  // rr_q still points at the revoked owner, so the search
                  // in IDLE favours the next requester.
                  grant_d  = '0;
                  state_d  = S_IDLE;
                  to_err_d = 1'b1;
                  to_d     = '0;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
`endif
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= RR_INIT;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         gap_q   <= gap_d;
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_q     <= '0;
         to_err_q <= 1'b0;
      end else begin
         to_q     <= to_d;
         to_err_q <= to_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: DUT a (GAP 16, timeout 8) and DUT b (GAP 0).
// Requester stimulus is steered to one DUT at a time via sel; a scoreboard
// queue holds the bytes expected on the selected tx port in order.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic [15:0] rd = '0;
   logic [1:0]  rv = '0, rl = '0;
   logic        txr = 1'b1;

   logic [1:0]  a_req_valid, a_req_last, a_req_ready, a_grant;
   logic [1:0]  b_req_valid, b_req_last, b_req_ready, b_grant;
   logic [7:0]  a_tx_data, b_tx_data;
   logic        a_tx_valid, b_tx_valid, a_busy, b_busy, a_to, b_to;
   logic        a_tx_ready, b_tx_ready;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   assign a_req_valid = sel ? 2'b00 : rv;
   assign a_req_last  = sel ? 2'b00 : rl;
   assign a_tx_ready  = sel ? 1'b1 : txr;
   assign b_req_valid = sel ? rv : 2'b00;
   assign b_req_last  = sel ? rl : 2'b00;
   assign b_tx_ready  = sel ? txr : 1'b1;

   uart_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(16), .TIMEOUT_CYCLES(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_data(rd), .req_valid(a_req_valid),
      .req_last(a_req_last), .req_ready(a_req_ready), .tx_data(a_tx_data),
      .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .grant(a_grant),
      .busy(a_busy), .timeout_err(a_to));

   uart_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_data(rd), .req_valid(b_req_valid),
      .req_last(b_req_last), .req_ready(b_req_ready), .tx_data(b_tx_data),
      .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .grant(b_grant),
      .busy(b_busy), .timeout_err(b_to));

   logic [1:0] m_grant, m_ready;
   logic [7:0] m_data;
   logic       m_valid, m_busy;
   assign m_grant = sel ? b_grant : a_grant;
   assign m_ready = sel ? b_req_ready : a_req_ready;
   assign m_data  = sel ? b_tx_data : a_tx_data;
   assign m_valid = sel ? b_tx_valid : a_tx_valid;
   assign m_busy  = sel ? b_busy : a_busy;

   // Scoreboard monitor: pops one expected byte per tx handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (!$onehot0(m_grant)) begin
            n_fail++;
            $display("FAIL grant_onehot: got %b, required one-hot or zero", m_grant);
         end
         if (m_valid && txr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got byte %h, required no transfer", m_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (m_data !== mon_exp) begin
                  n_fail++;
                  $display("FAIL sb_data: got %h, required %h", m_data, mon_exp);
               end
            end
         end
      end
   end

   task automatic send_pkt(input int r, input logic [31:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         rd[8*r +: 8] = bytes[8*i +: 8];
         rv[r] = 1'b1;
         rl[r] = (i == n - 1);
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!m_ready[r] && t < 200);
         if (!m_ready[r]) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: req %0d byte %0d never accepted", r, i);
         end
         @(posedge clk); #1;
      end
      rv[r] = 1'b0;
      rl[r] = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (m_busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (m_busy) begin
         n_fail++;
         $display("FAIL wait_idle: busy still %b, required 0", m_busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({a_grant, a_req_ready, a_tx_valid, a_tx_data, a_busy, a_to} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got g=%b r=%b v=%b d=%h b=%b t=%b, required all 0",
                  a_grant, a_req_ready, a_tx_valid, a_tx_data, a_busy, a_to);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_packet();
      int busy_n = 0;
      exp_q.push_back(8'h41); exp_q.push_back(8'h54); exp_q.push_back(8'h0D);
      fork
         send_pkt(0, 32'h000D5441, 3);
         begin
            @(negedge clk);
            n_checks++;
            if (a_grant !== 2'b00) begin
               n_fail++; $display("FAIL arb_latency: grant %b, required 00", a_grant);
            end
            @(negedge clk);
            n_checks++;
            if (a_grant !== 2'b01) begin
               n_fail++; $display("FAIL first_grant: grant %b, required 01", a_grant);
            end
            while (a_busy && busy_n < 100) begin
               busy_n++;
               @(negedge clk);
            end
            n_checks++;
            if (busy_n != 19) begin
               n_fail++; $display("FAIL busy_len: got %0d cycles, required 19", busy_n);
            end
            n_checks++;
            if (a_grant !== 2'b00) begin
               n_fail++; $display("FAIL grant_clear: grant %b, required 00", a_grant);
            end
         end
      join
      wait_idle();
   endtask

   task automatic test_backpressure();
      txr = 1'b0;
      exp_q.push_back(8'h7E);
      rd[7:0] = 8'h7E; rv[0] = 1'b1; rl[0] = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h7E || a_req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: cyc %0d v=%b d=%h rdy=%b, required 1,7e,0",
                     i, a_tx_valid, a_tx_data, a_req_ready[0]);
         end
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      txr = 1'b1;
      @(negedge clk);
      n_checks++;
      if (a_req_ready[0] !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: ready %b, required 1", a_req_ready[0]);
      end
      @(posedge clk); #1;
      rv[0] = 1'b0; rl[0] = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset_mid_packet();
      exp_q.push_back(8'h10);
      rd[7:0] = 8'h10; rv[0] = 1'b1; rl[0] = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rd[7:0] = 8'h20; txr = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({a_grant, a_req_ready, a_tx_valid, a_tx_data, a_busy, a_to} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got g=%b r=%b v=%b d=%h b=%b, required all 0",
                  a_grant, a_req_ready, a_tx_valid, a_tx_data, a_busy);
      end
      rv = '0; rl = '0; txr = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_simultaneous(input int first_pair);
      int h[4];
      int nh = 0;
      int cyc = 0;
      if (first_pair != 0) begin
         exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
         exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
      end else begin
         exp_q.push_back(8'h12); exp_q.push_back(8'h34);
         exp_q.push_back(8'h56); exp_q.push_back(8'h78);
      end
      fork
         send_pkt(0, first_pair != 0 ? 32'h0000BBAA : 32'h00003412, 2);
         send_pkt(1, first_pair != 0 ? 32'h0000DDCC : 32'h00007856, 2);
         begin
            while (nh < 4 && cyc < 200) begin
               @(negedge clk);
               cyc++;
               if (a_tx_valid && txr) begin
                  h[nh] = cyc;
                  nh++;
               end
            end
         end
      join
      n_checks++;
      if (nh != 4 || h[1] - h[0] != 1 || h[2] - h[1] != 18) begin
         n_fail++;
         $display("FAIL pair_timing: hs=%0d d01=%0d d12=%0d, required 4,1,18",
                  nh, h[1] - h[0], h[2] - h[1]);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int h[2];
      int nh = 0;
      logic r0_seen = 1'b0;
      sel = 1'b1;
      exp_q.push_back(8'h31); exp_q.push_back(8'h32);
      fork
         begin
            send_pkt(1, 32'h00000031, 1);
            send_pkt(1, 32'h00000032, 1);
         end
         begin
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (b_req_ready[0]) r0_seen = 1'b1;
               if (b_tx_valid && txr && nh < 2) begin
                  h[nh] = c;
                  nh++;
               end
            end
         end
      join
      n_checks++;
      if (nh != 2 || h[1] - h[0] != 2) begin
         n_fail++;
         $display("FAIL b2b_timing: hs=%0d spacing=%0d, required 2 and 2", nh, h[1] - h[0]);
      end
      n_checks++;
      if (r0_seen !== 1'b0) begin
         n_fail++; $display("FAIL b2b_ready0: req_ready[0] seen %b, required 0", r0_seen);
      end
      wait_idle();
      sel = 1'b0;
   endtask

   task automatic test_timeout();
      int k = 0;
      logic g1_seen = 1'b0, to_seen = 1'b0;
      exp_q.push_back(8'h55);
      rd = 16'h6655; rv = 2'b11; rl = 2'b10;
      repeat (2) @(negedge clk);
      n_checks++;
      if (a_grant !== 2'b01) begin
         n_fail++; $display("FAIL to_owner: grant %b, required 01", a_grant);
      end
      @(posedge clk); #1;
      rv[0] = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      while (!a_to && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (!a_to || k != 9 || a_grant !== 2'b00) begin
         n_fail++;
         $display("FAIL to_pulse: seen=%b at %0d grant=%b, required 1 at 9 grant 00",
                  a_to, k, a_grant);
      end
      exp_q.push_back(8'h66);
      @(negedge clk);
      n_checks++;
      if (a_to !== 1'b0 || a_grant !== 2'b10 || a_req_ready[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL to_regrant: err=%b grant=%b rdy1=%b, required 0,10,1",
                  a_to, a_grant, a_req_ready[1]);
      end
      @(posedge clk); #1;
      rv = '0; rl = '0;
      wait_idle();
`else
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (a_grant[1]) g1_seen = 1'b1;
         if (a_to) to_seen = 1'b1;
      end
      n_checks++;
      if (g1_seen !== 1'b0 || to_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout: grant1=%b err=%b, required 0,0", g1_seen, to_seen);
      end
      rv = '0; rl = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
`endif
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_backpressure();
      test_reset_mid_packet();
      test_simultaneous(1);
      test_simultaneous(0);
      test_back_to_back();
      test_timeout();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: %0d bytes pending, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
